// File: rtl/des_sbox_pkg.sv
//------------------------------------------------------------------------------
// Module   : des_sbox_pkg
// Brief    : Shared DES S-box definitions: S5 table, widths, inverse FSM states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package des_sbox_pkg;

  localparam int S5_ROW_W = 2;
  localparam int S5_COL_W = 4;

  typedef enum logic [1:0] {
    S5_INV_IDLE   = 2'd0,
    S5_INV_SEARCH = 2'd1,
    S5_INV_DONE   = 2'd2
  } s5_inv_state_e;

  // Indexed by {row, col}; each 16-entry row is a permutation of 0..15.
  localparam logic [3:0] S5_TABLE [0:63] = '{
    4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,
    4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
    4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,
    4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
    4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,
    4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
    4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13,
    4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3
  };

endpackage

`default_nettype wire

// File: rtl/s_box_s5_inverse_if.sv
//------------------------------------------------------------------------------
// Module   : s_box_s5_inverse_if
// Brief    : Request/result bundle for the S5 inverse lookup.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface s_box_s5_inverse_if;

  logic       S_Box_S5_Inv_Start;
  logic [4:1] S_Box_S5_Inv_Value;
  logic [2:1] S_Box_S5_Inv_Row;
  logic [6:1] S_Box_S5_Inv_Output;
  logic       S_Box_S5_Inv_Busy;
  logic       S_Box_S5_Inv_Finish_Flag;

  modport master (
    output S_Box_S5_Inv_Start, S_Box_S5_Inv_Value, S_Box_S5_Inv_Row,
    input  S_Box_S5_Inv_Output, S_Box_S5_Inv_Busy, S_Box_S5_Inv_Finish_Flag
  );

  modport slave (
    input  S_Box_S5_Inv_Start, S_Box_S5_Inv_Value, S_Box_S5_Inv_Row,
    output S_Box_S5_Inv_Output, S_Box_S5_Inv_Busy, S_Box_S5_Inv_Finish_Flag
  );

endinterface

`default_nettype wire

// File: rtl/s_box_s5_lookup.sv
//------------------------------------------------------------------------------
// Module   : s_box_s5_lookup
// Brief    : Combinational forward S5 lookup, (row, col) -> 4-bit value.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module s_box_s5_lookup
  import des_sbox_pkg::*;
(
  input  wire logic [S5_ROW_W-1:0] row,
  input  wire logic [S5_COL_W-1:0] col,
  output logic      [3:0]          value
);

  assign value = S5_TABLE[{row, col}];

endmodule

`default_nettype wire

// File: rtl/s_box_s5_inverse.sv
//------------------------------------------------------------------------------
// Module   : s_box_s5_inverse
// Brief    : Serial column-search inverse of DES S5; optional constant-time
//            search selected by macro S5_INV_CONST_TIME_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module s_box_s5_inverse
  import des_sbox_pkg::*;
(
  input wire logic             clk,
  input wire logic             rst,
  s_box_s5_inverse_if.slave    bus
);

  localparam logic [1:0] C_ST_IDLE   = 2'(S5_INV_IDLE);
  localparam logic [1:0] C_ST_SEARCH = 2'(S5_INV_SEARCH);
  localparam logic [1:0] C_ST_DONE   = 2'(S5_INV_DONE);

  logic [1:0]          r_state;
  logic [S5_COL_W-1:0] r_col;
  logic [3:0]          r_value;
  logic [S5_ROW_W-1:0] r_row;
  logic [5:0]          r_result;
  logic [5:0]          r_out;
  logic                r_finish;
  logic [3:0]          w_fwd;
  logic                w_hit;
`ifdef S5_INV_CONST_TIME_EN
  logic                r_found;
`endif

  s_box_s5_lookup u_lookup (
    .row   (r_row),
    .col   (r_col),
    .value (w_fwd)
  );

  // Last column is a forced match so the search always terminates.
  assign w_hit = (w_fwd == r_value) || (r_col == 4'hF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= C_ST_IDLE;
      r_col    <= '0;
      r_value  <= '0;
      r_row    <= '0;
      r_result <= '0;
      r_out    <= '0;
      r_finish <= 1'b0;
`ifdef S5_INV_CONST_TIME_EN
      r_found  <= 1'b0;
`endif
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (bus.S_Box_S5_Inv_Start) begin
            r_value <= bus.S_Box_S5_Inv_Value;
            r_row   <= bus.S_Box_S5_Inv_Row;
            r_col   <= '0;
            r_state <= C_ST_SEARCH;
`ifdef S5_INV_CONST_TIME_EN
            r_found <= 1'b0;
`endif
          end
        end
        C_ST_SEARCH: begin
`ifdef S5_INV_CONST_TIME_EN
          if (w_hit && !r_found) begin
            r_result <= {r_row[1], r_col, r_row[0]};
            r_found  <= 1'b1;
          end
          if (r_col == 4'hF) begin
            r_state <= C_ST_DONE;
          end else begin
            r_col <= r_col + 4'd1;
          end
`else
          if (w_hit) begin
            r_result <= {r_row[1], r_col, r_row[0]};
            r_state  <= C_ST_DONE;
          end else begin
            r_col <= r_col + 4'd1;
          end
`endif
        end
        C_ST_DONE: begin
          // Output and Finish update together so Output never changes early.
          r_out    <= r_result;
          r_finish <= 1'b1;
          r_state  <= C_ST_IDLE;
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign bus.S_Box_S5_Inv_Output      = r_out;
  assign bus.S_Box_S5_Inv_Busy        = (r_state != C_ST_IDLE);
  assign bus.S_Box_S5_Inv_Finish_Flag = r_finish;

endmodule

`default_nettype wire

// File: tb/tb_s_box_s5_inverse.sv
//------------------------------------------------------------------------------
// Module   : tb_s_box_s5_inverse
// Brief    : Self-checking bench for s_box_s5_inverse with a transaction model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_s_box_s5_inverse;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic cmp_en   = 1'b0;

  s_box_s5_inverse_if bus ();

  s_box_s5_inverse dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DES S5 rows, written independently of the design package.
  int T [0:63] = '{
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3
  };

  function automatic int m_col(input logic [1:0] row, input logic [3:0] val);
    for (int c = 0; c < 16; c++)
      if (T[row*16 + c] == int'(val)) return c;
    return 15;
  endfunction

  function automatic logic [5:0] m_res(input logic [1:0] row, input logic [3:0] val);
    logic [3:0] c;
    c = 4'(m_col(row, val));
    return {row[1], c, row[0]};
  endfunction

  function automatic int m_lat(input int col);
`ifdef S5_INV_CONST_TIME_EN
    return 17;
`else
    return col + 2;
`endif
  endfunction

  // Forward S5 on a 6-bit input: row = {b6, b1}, column = b5..b2.
  function automatic int fwd(input logic [5:0] x);
    return T[{x[5], x[0]}*16 + x[4:1]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: request accepted when idle, result after its latency.
  logic       m_busy, m_fin;
  logic [5:0] m_out, m_pend;
  int         m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_fin  <= 1'b0;
      m_out  <= '0;
      m_pend <= '0;
      m_left <= 0;
    end else begin
      m_fin <= 1'b0;
      if (!m_busy) begin
        if (bus.S_Box_S5_Inv_Start) begin
          m_busy <= 1'b1;
          m_left <= m_lat(m_col(bus.S_Box_S5_Inv_Row, bus.S_Box_S5_Inv_Value));
          m_pend <= m_res(bus.S_Box_S5_Inv_Row, bus.S_Box_S5_Inv_Value);
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_fin  <= 1'b1;
        m_out  <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cmp_en) begin
        chk("busy",   32'(bus.S_Box_S5_Inv_Busy),        32'(m_busy));
        chk("finish", 32'(bus.S_Box_S5_Inv_Finish_Flag), 32'(m_fin));
        chk("output", 32'(bus.S_Box_S5_Inv_Output),      32'(m_out));
      end
    end
  end

  task automatic run_req(input logic [1:0] row, input logic [3:0] val,
                         input logic [5:0] exp_out, input int exp_lat,
                         output logic [5:0] got);
    int n;
    @(posedge clk); #1;
    bus.S_Box_S5_Inv_Start = 1'b1;
    bus.S_Box_S5_Inv_Row   = row;
    bus.S_Box_S5_Inv_Value = val;
    @(posedge clk); #1;
    bus.S_Box_S5_Inv_Start = 1'b0;
    bus.S_Box_S5_Inv_Row   = ~row;
    bus.S_Box_S5_Inv_Value = ~val;
    n = 0;
    while (n < 40) begin
      @(posedge clk); n++; #1;
      if (bus.S_Box_S5_Inv_Finish_Flag) break;
    end
    if (n >= 40) chk("finish_timeout", 32'(n), 32'(0));
    if (exp_lat > 0) chk("latency", 32'(n), 32'(exp_lat));
    chk("result", 32'(bus.S_Box_S5_Inv_Output), 32'(exp_out));
    got = bus.S_Box_S5_Inv_Output;
  endtask

  logic [5:0] got;
  int         nfin;
  int         clat;

  initial begin
`ifdef S5_INV_CONST_TIME_EN
    clat = 1;
`else
    clat = 0;
`endif
    rst = 1'b1;
    bus.S_Box_S5_Inv_Start = 1'b0;
    bus.S_Box_S5_Inv_Row   = '0;
    bus.S_Box_S5_Inv_Value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.S_Box_S5_Inv_Busy), 32'(0));
    chk("rst_finish", 32'(bus.S_Box_S5_Inv_Finish_Flag), 32'(0));
    chk("rst_output", 32'(bus.S_Box_S5_Inv_Output), 32'(0));
    rst = 1'b0;
    cmp_en = 1'b1;

    // Hand-computed directed cases.
    run_req(2'b00, 4'd2, 6'b000000, clat ? 17 : 2,  got);
    run_req(2'b11, 4'd3, 6'b111111, 17,             got);
    run_req(2'b01, 4'd9, 6'b011011, clat ? 17 : 15, got);
    run_req(2'b10, 4'd0, 6'b111100, clat ? 17 : 16, got);

    // Second Start mid-search must be ignored.
    @(posedge clk); #1;
    bus.S_Box_S5_Inv_Start = 1'b1; bus.S_Box_S5_Inv_Row = 2'b01; bus.S_Box_S5_Inv_Value = 4'd9;
    @(posedge clk); #1;
    bus.S_Box_S5_Inv_Start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.S_Box_S5_Inv_Start = 1'b1; bus.S_Box_S5_Inv_Row = 2'b11; bus.S_Box_S5_Inv_Value = 4'd11;
    @(posedge clk); #1;
    bus.S_Box_S5_Inv_Start = 1'b0;
    nfin = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.S_Box_S5_Inv_Finish_Flag) nfin++;
    end
    chk("single_finish", 32'(nfin), 32'(1));
    chk("ignored_start_result", 32'(bus.S_Box_S5_Inv_Output), 32'(6'b011011));

    // Asynchronous reset in the middle of a Row=3, Value=3 search.
    @(posedge clk); #1;
    bus.S_Box_S5_Inv_Start = 1'b1; bus.S_Box_S5_Inv_Row = 2'b11; bus.S_Box_S5_Inv_Value = 4'd3;
    @(posedge clk); #1;
    bus.S_Box_S5_Inv_Start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",   32'(bus.S_Box_S5_Inv_Busy), 32'(0));
    chk("arst_output", 32'(bus.S_Box_S5_Inv_Output), 32'(0));
    chk("arst_finish", 32'(bus.S_Box_S5_Inv_Finish_Flag), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    nfin = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.S_Box_S5_Inv_Finish_Flag) nfin++;
    end
    chk("no_finish_after_rst", 32'(nfin), 32'(0));
    run_req(2'b11, 4'd3, 6'b111111, 17, got);

    // Exhaustive round trip through the forward box.
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < 16; v++) begin
        run_req(2'(r), 4'(v), m_res(2'(r), 4'(v)), m_lat(m_col(2'(r), 4'(v))), got);
        chk("fwd_value", 32'(fwd(got)), 32'(v));
        chk("fwd_row",   32'({got[5], got[0]}), 32'(r));
      end
    end

    // Random traffic; the model decides which Starts are accepted.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      bus.S_Box_S5_Inv_Start = ($urandom_range(0, 5) == 0);
      bus.S_Box_S5_Inv_Row   = 2'($urandom);
      bus.S_Box_S5_Inv_Value = 4'($urandom);
    end
    @(posedge clk); #1;
    bus.S_Box_S5_Inv_Start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("final_idle", 32'(bus.S_Box_S5_Inv_Busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
